// File: rtl/fxdiv_pkg.sv
// Shared types and helpers for the fixed-point divider family: FSM state codes, iteration count
// and saturation constants.
package fxdiv_pkg;

  typedef logic [1:0] fxdiv_state_t;

  localparam fxdiv_state_t StIdle = 2'd0;
  localparam fxdiv_state_t StCalc = 2'd1;
  localparam fxdiv_state_t StDone = 2'd2;

  // Result bits plus one guard bit for rounding.
  function automatic int fxdiv_niter(int woi, int wof);
    return woi + wof + 1;
  endfunction

  function automatic logic [63:0] fxdiv_max_pos(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fxdiv_min_neg(int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/seq_fixed_point_div_if.sv
// Operand/result handshake bundle for seq_fixed_point_div. The master drives operands and
// out_ready; the slave (divider) drives in_ready and the result.
interface seq_fixed_point_div_if #(
  parameter int unsigned WA = 16,
  parameter int unsigned WB = 16,
  parameter int unsigned WO = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [WA-1:0] dividend;
  logic [WB-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [WO-1:0] out;
  logic          overflow;
  logic          div0;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, out, overflow, div0
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, out, overflow, div0
  );
endinterface

// File: rtl/fxdiv_sat_round.sv
// Combinational rounding and saturation of an unsigned quotient magnitude into a signed
// two's-complement result.
module fxdiv_sat_round
  import fxdiv_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter bit          Round = 1'b1
) (
  input  logic [Width-1:0] mag_i,
  input  logic             guard_i,
  input  logic             neg_i,
  input  logic             ovf_i,
  output logic [Width-1:0] out_o,
  output logic             ovf_o
);
  localparam logic [Width-1:0] MaxPos = Width'(fxdiv_max_pos(Width));
  localparam logic [Width-1:0] MinNeg = Width'(fxdiv_min_neg(Width));

  logic [Width:0] mag_r;
  logic           sat;

  always_comb begin
    // Extra top bit keeps the rounding carry visible to the saturation test.
    mag_r = {1'b0, mag_i} + {{Width{1'b0}}, Round & guard_i};
    if (neg_i) begin
      sat   = ovf_i || (mag_r > {1'b0, MinNeg});
      out_o = sat ? MinNeg : -mag_r[Width-1:0];
    end else begin
      sat   = ovf_i || (mag_r > {1'b0, MaxPos});
      out_o = sat ? MaxPos : mag_r[Width-1:0];
    end
    ovf_o = sat;
  end

endmodule

// File: rtl/seq_fixed_point_div.sv
// Iterative signed fixed-point divider, one quotient bit per cycle, with valid/ready on both sides.
// Optional macro FXDIV_ABORT_EN adds an abort input that drops an operation in flight.
module seq_fixed_point_div
  import fxdiv_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input logic clk,
  input logic rst,
`ifdef FXDIV_ABORT_EN
  input logic abort,
`endif
  seq_fixed_point_div_if.slave bus
);
  localparam int WA    = WIIA + WIFA;
  localparam int WB    = WIIB + WIFB;
  localparam int WM    = WOI + WOF;
  localparam int NITER = fxdiv_niter(WOI, WOF);
  // Numerator scaling so the integer quotient carries WOF fraction bits plus the guard bit.
  localparam int S     = WIFB - WIFA + WOF + 1;
  localparam int SP    = (S > 0) ? S : 0;
  localparam int SN    = (S < 0) ? -S : 0;
  localparam int WX    = WA + WB + SP + NITER;
  localparam int CW    = $clog2(NITER);

  fxdiv_state_t      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NITER-1:0]  acc_q, acc_d;
  logic [WB-1:0]     rem_q, rem_d;
  logic [WB-1:0]     b_q, b_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              div0_q, div0_d;

  logic              a_neg, b_neg;
  logic [WA-1:0]     a_mag;
  logic [WB-1:0]     b_mag;
  logic [WX-1:0]     x_full, x_hi;
  logic [WB:0]       rem2;
  logic [WM-1:0]     res;
  logic              res_ovf;

  always_comb begin
    a_neg  = bus.dividend[WA-1];
    b_neg  = bus.divisor[WB-1];
    a_mag  = a_neg ? -bus.dividend : bus.dividend;
    b_mag  = b_neg ? -bus.divisor : bus.divisor;
    x_full = (WX'(a_mag) << SP) >> SN;
    // Bits above the iterated window; if they already reach the divisor the quotient overflows.
    x_hi   = x_full >> NITER;
    rem2   = {rem_q, acc_q[NITER-1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    b_d     = b_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    div0_d  = div0_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          b_d    = b_mag;
          cnt_d  = '0;
          div0_d = (b_mag == '0);
          if (b_mag == '0) begin
            state_d = StDone;
            acc_d   = '0;
            neg_d   = a_neg;
            ovf_d   = (a_mag != '0);
          end else begin
            state_d = StCalc;
            acc_d   = x_full[NITER-1:0];
            rem_d   = x_hi[WB-1:0];
            neg_d   = (a_neg ^ b_neg) && (a_mag != '0);
            ovf_d   = (x_hi >= WX'(b_mag));
          end
        end
      end
      StCalc: begin
        // acc shifts numerator bits out the top and quotient bits in at the bottom.
        if (rem2 >= {1'b0, b_q}) begin
          rem_d = rem2[WB-1:0] - b_q;
          acc_d = {acc_q[NITER-2:0], 1'b1};
        end else begin
          rem_d = rem2[WB-1:0];
          acc_d = {acc_q[NITER-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NITER - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef FXDIV_ABORT_EN
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      div0_q  <= div0_d;
    end
  end

  fxdiv_sat_round #(
    .Width(WM),
    .Round(ROUND != 0)
  ) u_sat_round (
    .mag_i  (acc_q[NITER-1:1]),
    .guard_i(acc_q[0]),
    .neg_i  (neg_q),
    .ovf_i  (ovf_q),
    .out_o  (res),
    .ovf_o  (res_ovf)
  );

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out       = res;
  assign bus.overflow  = res_ovf;
  assign bus.div0      = div0_q;

endmodule

// File: tb/tb_seq_fixed_point_div.sv
// Self-checking bench for seq_fixed_point_div with default Q8.8 widths; a second instance
// covers truncation (ROUND=0).
module tb_seq_fixed_point_div;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
    logic        div0;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        div0;
  } vec_t;

  localparam int NVEC = 13;
  localparam vec_t VECS [NVEC] = '{
    '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0},
    '{16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0},
    '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0},
    '{16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0},
    '{16'h7F00, 16'h0010, 16'h7FFF, 1'b1, 1'b0},
    '{16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0},
    '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0},
    '{16'h8BB5, 16'h0000, 16'h8000, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1},
    '{16'h0100, 16'h0000, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0},
    '{16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0},
    '{16'hFF80, 16'h0300, 16'hFFD5, 1'b0, 1'b0}
  };

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;
  exp_t exp_q [$];

  seq_fixed_point_div_if #(.WA(16), .WB(16), .WO(16)) bus ();
  seq_fixed_point_div_if #(.WA(16), .WB(16), .WO(16)) bus0 ();

`ifdef FXDIV_ABORT_EN
  logic abort;
`endif

  seq_fixed_point_div dut (
    .clk(clk),
    .rst(rst),
`ifdef FXDIV_ABORT_EN
    .abort(abort),
`endif
    .bus(bus)
  );

  seq_fixed_point_div #(.ROUND(0)) dut_trunc (
    .clk(clk),
    .rst(rst),
`ifdef FXDIV_ABORT_EN
    .abort(1'b0),
`endif
    .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference from the arithmetic definition: scaled magnitude quotient, guard bit, sign, clamp.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input bit rnd);
    exp_t   e;
    longint sa, sb, num, den, g2, m;
    bit     neg;
    sa     = longint'($signed(a));
    sb     = longint'($signed(b));
    e.div0 = (sb == 0);
    if (sb == 0) begin
      if (sa > 0)      begin e.res = 16'h7FFF; e.ovf = 1'b1; end
      else if (sa < 0) begin e.res = 16'h8000; e.ovf = 1'b1; end
      else             begin e.res = 16'h0000; e.ovf = 1'b0; end
    end else begin
      num = ((sa < 0) ? -sa : sa) * (longint'(1) << 17);  // 2^(WIFB+WOF+1)
      den = ((sb < 0) ? -sb : sb) * (longint'(1) << 8);   // 2^WIFA
      g2  = num / den;
      m   = g2 / 2;
      if (rnd) m = m + (g2 % 2);
      neg = ((sa < 0) != (sb < 0)) && (sa != 0);
      if (!neg && m > 32767)     begin e.res = 16'h7FFF; e.ovf = 1'b1; end
      else if (neg && m > 32768) begin e.res = 16'h8000; e.ovf = 1'b1; end
      else begin
        e.res = neg ? 16'(-m) : 16'(m);
        e.ovf = 1'b0;
      end
    end
    return e;
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        chk("out", 32'(bus.out), 32'(exp_q[0].res));
        chk("overflow", 32'(bus.overflow), 32'(exp_q[0].ovf));
        chk("div0", 32'(bus.div0), 32'(exp_q[0].div0));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit wait_done,
                       output int lat);
    int n;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    exp_q.push_back(model(a, b, 1'b1));
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 16'($urandom);
    lat = 1;
    if (wait_done) begin
      while (!bus.out_valid && lat < 100) begin
        @(posedge clk);
        #1;
        lat++;
      end
      if (!bus.out_valid) chk("result_timeout", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out"}, 32'(bus.out), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, "_div0"}, 32'(bus.div0), 32'd0);
  endtask

  initial begin
    int   lat;
    int   n;
    bit   fired;
    exp_t m;
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.dividend  = '0;
    bus0.divisor   = '0;
    bus0.out_ready = 1'b1;
`ifdef FXDIV_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < NVEC; i++) begin
      m = model(VECS[i].a, VECS[i].b, 1'b1);
      chk($sformatf("model_%0d", i), 32'(m), 32'({VECS[i].res, VECS[i].ovf, VECS[i].div0}));
      do_op(VECS[i].a, VECS[i].b, 1'b1, lat);
      chk($sformatf("latency_%0d", i), 32'(lat), VECS[i].div0 ? 32'd1 : 32'd18);
      @(posedge clk);
      #1;
    end

    // Truncating instance: 2/3 -> 0x00AA.
    m = model(16'h0200, 16'h0300, 1'b0);
    chk("model_trunc", 32'(m.res), 32'h00AA);
    bus0.dividend = 16'h0200;
    bus0.divisor  = 16'h0300;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    n = 0;
    while (!bus0.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("trunc_valid", 32'(bus0.out_valid), 32'd1);
    chk("trunc_out", 32'(bus0.out), 32'(m.res));
    chk("trunc_overflow", 32'(bus0.overflow), 32'(m.ovf));
    @(posedge clk);
    #1;

    // Backpressure: result held, no new acceptance while stalled.
    bus.out_ready = 1'b0;
    do_op(16'h0200, 16'h0300, 1'b1, lat);
    chk("bp_latency", 32'(lat), 32'd18);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 16'h0100;
      bus.divisor  = 16'h0300;
      chk($sformatf("bp_in_ready_%0d", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_out_valid_%0d", k), 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a calculation discards it.
    do_op(16'h7F00, 16'h0010, 1'b0, lat);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk_reset_vals("midrst");
    fired = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) fired = 1'b1;
    end
    chk("midrst_no_out", 32'(fired), 32'd0);

`ifdef FXDIV_ABORT_EN
    do_op(16'h0100, 16'h0300, 1'b0, lat);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    fired = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) fired = 1'b1;
    end
    chk("abort_no_out", 32'(fired), 32'd0);
    do_op(16'h0300, 16'h0200, 1'b1, lat);
    chk("abort_next_out", 32'(bus.out), 32'h0180);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
